seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised, run-time-programmable Mealy serial sequence detector; successor to fixed-pattern FSM detectors.
//  Watches a 1-bit serial stream (qualified by in_valid) for a pattern of 1..MAX_LEN bits (MSB first).
//  Outputs a same-cycle Mealy match pulse, a registered copy and a saturating match counter.
//  Supports overlapping and non-overlapping detection.
// PARAMETERS
//  MAX_LEN  8         longest supported pattern, bits (>=2)
//  LEN_W    4         width of cfg_len; must hold MAX_LEN
//  CNT_W    8         match counter width
//  PAT_RST  8'h00     pattern register reset value (MAX_LEN bits)
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  in_valid     in   1        in is a stream bit this cycle
//  in           in   1        serial data bit
//  cfg_load     in   1        load cfg_* this cycle
//  cfg_pattern  in   MAX_LEN  pattern, right-aligned; bit [len-1] is first bit received
//  cfg_len      in   LEN_W    pattern length
//  cfg_overlap  in   1        1 = overlapping, 0 = non-overlapping
//  out          out  1        Mealy match, combinational, same cycle as final bit
//  out_q        out  1        out registered (1-cycle latency)
//  match_count  out  CNT_W    saturating count of matches
// BEHAVIOUR
//  - Reset (sync, active-high): pat<=PAT_RST, len<=MAX_LEN, ovl<=1, hist<=0, fill<=0, out_q<=0, match_count<=0; out forced 0.
//  - State: hist[MAX_LEN-2:0] (last bits received, newest in LSB); fill = valid bits held, saturating at MAX_LEN-1.
//  - Window w = {hist,in}; out = in_valid & ~reset & ~cfg_load & (fill >= len-1) & (w[len-1:0] == pat[len-1:0]).
//  - Accepted bit (in_valid & ~cfg_load): hist <= {hist, in}.
//    * on out with ovl=0: fill <= 0, next match needs len fresh bits;
//    * otherwise fill <= min(fill+1, MAX_LEN-1).
//  - in_valid=0: hist/fill hold, out=0. Gaps never break a partial match.
//  - cfg_load: pat/len/ovl captured; hist, fill cleared; match_count holds.
//    Same-cycle in_valid bit is dropped and produces no match.
//  - cfg_len clamp: 0 -> 1; >MAX_LEN -> MAX_LEN. len=1 matches every bit equal to pat[0].
//  - out_q <= out every cycle. match_count increments on out, sticks at 2^CNT_W-1.
//  - Reset mid-pattern discards history; no match may complete using pre-reset bits.
//  - Combinational path in->out is intentional (Mealy); consumers needing timing closure use out_q.
// STRUCTURE
//  - Package seq_detect_pkg: default MAX_LEN/CNT_W constants, clamp function for cfg_len.
//  - One sub-module: sat_counter (CNT_W, inc, clear, count); also reusable elsewhere.
//  - Window compare: masked equality, mask = (1<<len)-1; no per-pattern hand-coded state case.
// TESTING
//  1 pat=4'b1011 len=4 ovl=1, stream 1,0,1,1,0,1,1 -> out high on bits 4 and 7, match_count=2, out_q one cycle later.
//  2 Same, ovl=0 -> out high on bit 4 only, match_count=1.
//  3 Case 1 with in_valid=0 cycles between every bit -> identical matches; out never high while in_valid=0.
//  4 Stream 1,0,1; reset pulse; then 1 -> no match; all outputs 0 during and after reset cycle.
//  5 cfg_load same cycle as final '1' of 1011 -> no match, bit dropped.
//    Then cfg_len=0, pat=1: each '1' matches, each '0' does not.
//  6 CNT_W=2, 5 matches with len=1 -> match_count goes 1,2,3,3,3; out still pulses each time.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  // Map a requested pattern length into the legal range 1..max_len.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear has priority.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time programmable Mealy serial pattern detector (pattern MSB first, 1..MAX_LEN bits),
// with registered match copy and saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned         MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned         LEN_W   = DEF_LEN_W,
  parameter int unsigned         CNT_W   = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]  PAT_RST = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic               out_q,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_out_q;

  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_accept;
  logic               w_full;
  logic               w_hit;
  logic               w_out;

  assign w_win         = {r_hist, in};
  assign w_len_clamped = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

  // Only the low r_len bits of the window take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
  end

  assign w_accept = in_valid & ~cfg_load;
  assign w_full   = (r_fill >= (r_len - LEN_W'(1)));
  assign w_hit    = (((w_win ^ r_pat) & w_mask) == '0);
  assign w_out    = w_accept & ~reset & w_full & w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PAT_RST;
      r_len  <= LEN_MAX;
      r_ovl  <= 1'b1;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_len_clamped;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      r_hist <= w_win[MAX_LEN-2:0];
      // Non-overlapping mode restarts the fill so the next match needs fresh bits.
      if (w_out && !r_ovl) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= w_out;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk     (clk),
    .i_clear (reset),
    .i_inc   (w_out),
    .o_count (match_count)
  );

  assign out   = w_out;
  assign out_q = r_out_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: Mealy out checked in-cycle, out_q via a scoreboard queue.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       out;
  logic       out_q;
  logic [7:0] match_count;
  logic       out2;
  logic       out_q2;
  logic [1:0] match_count2;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic        outq_sb[$];

  always #5 clk = ~clk;

  seq_detect_param #(
    .MAX_LEN (8),
    .LEN_W   (4),
    .CNT_W   (8),
    .PAT_RST (8'h00)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .out_q       (out_q),
    .match_count (match_count)
  );

  seq_detect_param #(
    .MAX_LEN (8),
    .LEN_W   (4),
    .CNT_W   (2),
    .PAT_RST (8'h00)
  ) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out2),
    .out_q       (out_q2),
    .match_count (match_count2)
  );

  // Drive one cycle, check the Mealy output before the edge, then check out_q after it.
  task automatic do_cycle(input logic rst, input logic ld, input logic v, input logic d,
                          input logic exp_out, input string tag);
    logic exp_q;
    @(negedge clk);
    reset    = rst;
    cfg_load = ld;
    in_valid = v;
    in       = d;
    #1;
    n_cmp++;
    assert (out === exp_out) else begin
      n_fail++;
      $error("FAIL %s out: got %0b expected %0b", tag, out, exp_out);
    end
    n_cmp++;
    assert (out2 === exp_out) else begin
      n_fail++;
      $error("FAIL %s out2: got %0b expected %0b", tag, out2, exp_out);
    end
    outq_sb.push_back(exp_out);
    @(posedge clk);
    #1;
    exp_q = outq_sb.pop_front();
    n_cmp++;
    assert (out_q === exp_q) else begin
      n_fail++;
      $error("FAIL %s out_q: got %0b expected %0b", tag, out_q, exp_q);
    end
  endtask

  task automatic check_count(input logic [7:0] exp_cnt, input string tag);
    n_cmp++;
    assert (match_count === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s match_count: got %0d expected %0d", tag, match_count, exp_cnt);
    end
  endtask

  task automatic check_count2(input logic [1:0] exp_cnt, input string tag);
    n_cmp++;
    assert (match_count2 === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s match_count2: got %0d expected %0d", tag, match_count2, exp_cnt);
    end
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
  endtask

  initial begin
    logic [6:0] s1011;
    logic [7:0] sa5;
    s1011 = 7'b1011011;
    sa5   = 8'hA5;
    reset = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0;
    set_cfg(8'h00, 4'd0, 1'b0);

    do_cycle(1, 0, 0, 0, 0, "rst0");
    do_cycle(1, 0, 1, 0, 0, "rst1");
    check_count(8'd0, "rst");
    check_count2(2'd0, "rst");

    // Test 1: 1011 overlapping
    set_cfg(8'b0000_1011, 4'd4, 1'b1);
    do_cycle(0, 1, 0, 0, 0, "t1_load");
    for (int i = 6; i >= 0; i--) begin
      do_cycle(0, 0, 1, s1011[i], (i == 3 || i == 0), $sformatf("t1_bit%0d", 7 - i));
    end
    check_count(8'd2, "t1");

    // Test 2: non-overlapping
    set_cfg(8'b0000_1011, 4'd4, 1'b0);
    do_cycle(0, 1, 0, 0, 0, "t2_load");
    for (int i = 6; i >= 0; i--) begin
      do_cycle(0, 0, 1, s1011[i], (i == 3), $sformatf("t2_bit%0d", 7 - i));
    end
    check_count(8'd3, "t2");

    // Test 3: gaps between every bit, invalid cycles drive a '1' on in
    set_cfg(8'b0000_1011, 4'd4, 1'b1);
    do_cycle(0, 1, 0, 0, 0, "t3_load");
    for (int i = 6; i >= 0; i--) begin
      do_cycle(0, 0, 1, s1011[i], (i == 3 || i == 0), $sformatf("t3_bit%0d", 7 - i));
      do_cycle(0, 0, 0, 1, 0, $sformatf("t3_gap%0d", 7 - i));
    end
    check_count(8'd5, "t3");

    // Test 4: reset mid-pattern discards history
    do_cycle(0, 1, 0, 0, 0, "t4_load");
    do_cycle(0, 0, 1, 1, 0, "t4_b1");
    do_cycle(0, 0, 1, 0, 0, "t4_b2");
    do_cycle(0, 0, 1, 1, 0, "t4_b3");
    do_cycle(1, 0, 1, 1, 0, "t4_rst");
    check_count(8'd0, "t4_rst");
    do_cycle(0, 0, 1, 1, 0, "t4_after");
    check_count(8'd0, "t4_after");

    // Test 5: load in the cycle of the final '1' drops it; new cfg len=0 clamps to 1
    do_cycle(0, 1, 0, 0, 0, "t5_load");
    do_cycle(0, 0, 1, 1, 0, "t5_b1");
    do_cycle(0, 0, 1, 0, 0, "t5_b2");
    do_cycle(0, 0, 1, 1, 0, "t5_b3");
    set_cfg(8'h01, 4'd0, 1'b1);
    do_cycle(0, 1, 1, 1, 0, "t5_drop");
    check_count(8'd0, "t5_drop");
    do_cycle(0, 0, 1, 1, 1, "t5_l1_a");
    do_cycle(0, 0, 1, 0, 0, "t5_l1_b");
    do_cycle(0, 0, 1, 1, 1, "t5_l1_c");
    do_cycle(0, 0, 1, 0, 0, "t5_l1_d");
    check_count(8'd2, "t5");

    // Test 6: CNT_W=2 saturation with len=1
    do_cycle(1, 0, 0, 0, 0, "t6_rst");
    check_count2(2'd0, "t6_rst");
    set_cfg(8'h01, 4'd1, 1'b0);
    do_cycle(0, 1, 0, 0, 0, "t6_load");
    for (int k = 1; k <= 5; k++) begin
      do_cycle(0, 0, 1, 1, 1, $sformatf("t6_m%0d", k));
      check_count2((k >= 3) ? 2'd3 : 2'(k), $sformatf("t6_m%0d", k));
    end
    check_count(8'd5, "t6");

    // Length above MAX_LEN clamps to 8: full-width pattern A5
    set_cfg(8'hA5, 4'd15, 1'b1);
    do_cycle(0, 1, 0, 0, 0, "t7_load");
    for (int i = 7; i >= 0; i--) begin
      do_cycle(0, 0, 1, sa5[i], (i == 0), $sformatf("t7_bit%0d", 8 - i));
    end
    check_count(8'd6, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
